// File: rtl/bcd_serial_rx.sv
// bcd_serial_rx: assembles strobed serial bits into BCD digits, flags illegal/framing/overrun, presents D/C/B/A via valid/ready.
module bcd_serial_rx #(
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit DROP_INVALID = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sdi,
    input  logic sdi_vld,
    input  logic sdi_sof,
    input  logic dig_rdy,
    output logic dig_vld,
    output logic D,
    output logic C,
    output logic B,
    output logic A,
    output logic err_illegal,
    output logic err_framing,
    output logic err_overrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, nxt_state;
    logic [1:0] bcnt, nxt_bcnt;
    logic [3:0] sreg, nxt_sreg, shifted;
    logic done, framing, illegal, accept, load, overrun, nxt_vld;
    assign shifted = MSB_FIRST ? {sreg[2:0], sdi} : {sdi, sreg[3:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bcnt  <= 2'd0;
            sreg  <= 4'd0;
        end else begin
            state <= nxt_state;
            bcnt  <= nxt_bcnt;
            sreg  <= nxt_sreg;
        end
    end
    always_comb begin
        nxt_state = state;
        nxt_bcnt  = bcnt;
        nxt_sreg  = sreg;
        if (sdi_vld && sdi_sof) begin
            nxt_state = SHIFT;
            nxt_bcnt  = 2'd1;
            nxt_sreg  = MSB_FIRST ? {3'd0, sdi} : {sdi, 3'd0};
        end else if (sdi_vld && state == SHIFT) begin
            nxt_sreg  = shifted;
            nxt_bcnt  = bcnt + 2'd1;
            nxt_state = (bcnt == 2'd3) ? IDLE : SHIFT;
        end
    end
    always_comb begin
        done    = sdi_vld && !sdi_sof && state == SHIFT && bcnt == 2'd3;
        framing = sdi_vld && (sdi_sof ? state == SHIFT : state == IDLE);
        illegal = done && shifted > 4'd9;
        accept  = done && !(illegal && DROP_INVALID);
        load    = accept && (!dig_vld || dig_rdy);
        overrun = accept && dig_vld && !dig_rdy;
        nxt_vld = load || (dig_vld && !dig_rdy);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_vld      <= 1'b0;
            {D, C, B, A} <= 4'd0;
            err_illegal  <= 1'b0;
            err_framing  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            dig_vld     <= nxt_vld;
            err_illegal <= illegal;
            err_framing <= framing;
            err_overrun <= overrun;
            if (load)
                {D, C, B, A} <= shifted;
        end
    end
endmodule
